// File: rtl/otn_link_pkg.sv
// Shared constants and helpers for the OTN serial-link emulator.
package otn_link_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic        DATA_IDLE = 1'b1;
  localparam logic        ACK_IDLE  = 1'b0;
  localparam int          ERR_CNT_W = 16;

  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  // Galois right-shift step; feedback taps apply when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/otn_delay_line.sv
// Fixed-latency shift register; every stage resets to RST_VAL so a reset flushes in-flight bits.
module otn_delay_line
  import otn_link_pkg::*;
#(
  parameter int   WIDTH   = 1,
  parameter int   DEPTH   = 8,
  parameter logic RST_VAL = ACK_IDLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= {WIDTH{RST_VAL}};
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/otn_link_emu.sv
// Serial-link emulator: delayed data/ack lanes with bit-error injection, link-down and flip counting.
module otn_link_emu
  import otn_link_pkg::*;
#(
  parameter int          LANES        = 1,
  parameter int          DATA_DELAY   = 8,
  parameter int          ACK_DELAY    = 8,
  parameter int          ERR_INTERVAL = 1024,
  parameter logic [15:0] ERR_MASK     = 16'h03FF,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_link_up,
  input  logic                 i_corrupt_en,
  input  logic                 i_corrupt_mode,
  input  logic                 i_cnt_clr,
  input  logic [LANES-1:0]     i_otn_tx_data,
  output logic [LANES-1:0]     o_otn_rx_data,
  input  logic [LANES-1:0]     i_otn_rx_ack,
  output logic [LANES-1:0]     o_otn_tx_ack,
  output logic                 o_err_pulse,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int PER_W = (ERR_INTERVAL > 1) ? $clog2(ERR_INTERVAL) : 1;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(ERR_INTERVAL - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

  logic [15:0]      lfsr;
  logic [PER_W-1:0] per_cnt;
  logic [PTR_W-1:0] lane_ptr;
  logic             flip_p0;
  logic             flip_p1;
  logic [LANES-1:0] flip_mask;
  logic [LANES-1:0] data_entry;
  logic [LANES-1:0] ack_entry;
  err_cnt_t         err_cnt;

  function automatic err_cnt_t sat_inc(input err_cnt_t v);
    return (v == '1) ? v : v + err_cnt_t'(1);
  endfunction

  // Stage p0: flip decision and delay-line entry values
  always_comb begin
    flip_p0 = 1'b0;
    if (i_link_up && i_corrupt_en)
      flip_p0 = i_corrupt_mode ? ((lfsr & ERR_MASK) == 16'h0000) : (per_cnt == PER_LAST);
  end

  always_comb begin
    flip_mask = '0;
    if (flip_p0) flip_mask[lane_ptr] = 1'b1;
  end

  assign data_entry = i_link_up ? (i_otn_tx_data ^ flip_mask) : {LANES{DATA_IDLE}};
  assign ack_entry  = i_link_up ? i_otn_rx_ack : {LANES{ACK_IDLE}};

  // Stage p1: injector state, registered pulse and saturating count
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lfsr     <= LFSR_SEED;
      per_cnt  <= '0;
      lane_ptr <= '0;
      flip_p1  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (i_corrupt_en) lfsr <= lfsr_next(lfsr);
      if (!i_corrupt_en || i_corrupt_mode)
        per_cnt <= '0;
      else if (i_link_up)
        per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
      if (flip_p0) lane_ptr <= (lane_ptr == PTR_LAST) ? '0 : lane_ptr + PTR_W'(1);
      flip_p1 <= flip_p0;
      // A clear wins over a coincident flip; the pulse still reports that flip.
      if (i_cnt_clr)
        err_cnt <= '0;
      else if (flip_p0)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  assign o_err_pulse = flip_p1;
  assign o_err_cnt   = err_cnt;

  otn_delay_line #(
    .WIDTH  (LANES),
    .DEPTH  (DATA_DELAY),
    .RST_VAL(DATA_IDLE)
  ) u_data_dly (
    .clk  (i_clk),
    .rst_n(i_rst),
    .din  (data_entry),
    .dout (o_otn_rx_data)
  );

  otn_delay_line #(
    .WIDTH  (LANES),
    .DEPTH  (ACK_DELAY),
    .RST_VAL(ACK_IDLE)
  ) u_ack_dly (
    .clk  (i_clk),
    .rst_n(i_rst),
    .din  (ack_entry),
    .dout (o_otn_tx_ack)
  );

endmodule

// File: doc/otn_link_emu.md
Name: otn_link_emu

Overview:
- Parametrised serial-link emulator between sender and receiver instances in a single-FPGA loopback top, generalising the direct wire connection.
- Carries LANES independent serial data lanes (sender to receiver) and LANES ack lanes (receiver to sender).
- Adds configurable propagation delay on both paths, deterministic or pseudo-random bit-error injection on the data path, link-down emulation, and an error counter.
- Used to exercise CRC/ARQ recovery with controlled, repeatable impairments.

Parameters:
- LANES, 1: number of data/ack lane pairs; legal range 1..8.
- DATA_DELAY, 8: data-path latency in cycles; must be at least 1.
- ACK_DELAY, 8: ack-path latency in cycles; must be at least 1.
- ERR_INTERVAL, 1024: periodic mode, one flip every ERR_INTERVAL enabled cycles; must be at least 1.
- ERR_MASK, 16'h03FF: LFSR mode, a flip occurs when (lfsr & ERR_MASK) == 0.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_link_up  in  1  1 = link carries traffic; 0 = link down
- i_corrupt_en  in  1  enables error injection
- i_corrupt_mode  in  1  0 = periodic, 1 = LFSR
- i_cnt_clr  in  1  synchronous clear of o_err_cnt
- i_otn_tx_data  in  LANES  serial data from sender
- o_otn_rx_data  out  LANES  delayed, possibly corrupted data to receiver
- i_otn_rx_ack  in  LANES  ack from receiver
- o_otn_tx_ack  out  LANES  delayed ack to sender
- o_err_pulse  out  1  registered, high for one cycle per injected flip
- o_err_cnt  out  16  saturating count of injected flips

Behaviour:
- Reset (i_rst low, asynchronous):
  - Data delay line fills with all ones (idle), so o_otn_rx_data = all ones.
  - Ack delay line fills with all zeros, so o_otn_tx_ack = 0.
  - o_err_cnt = 0, o_err_pulse = 0, lfsr = LFSR_SEED, period counter = 0, lane pointer = 0.
  - Asserting reset mid-stream discards all in-flight bits. After release, idle values continue until new data traverses the delay.
- Latency: data on i_otn_tx_data in cycle n appears on o_otn_rx_data in cycle n+DATA_DELAY. The ack path behaves the same with ACK_DELAY. There are no combinational paths from inputs to outputs.
- Delay-line entry values:
  - Data entry = i_otn_tx_data XOR flip_mask when i_link_up = 1; all ones when i_link_up = 0.
  - Ack entry = i_otn_rx_ack when i_link_up = 1; all zeros when i_link_up = 0.
  - Link-down and link-up transitions therefore take effect on the outputs after the corresponding delay.
- flip_mask: at most one bit set per cycle, at the lane pointer position. The flip condition is:
  - i_link_up = 1, and
  - i_corrupt_en = 1, and
  - in periodic mode, counter == ERR_INTERVAL-1; in LFSR mode, (lfsr & ERR_MASK) == 0.
- Periodic counter:
  - Increments each cycle that i_link_up and i_corrupt_en are both high.
  - Wraps to 0 on reaching ERR_INTERVAL-1.
  - Forced to 0 whenever i_corrupt_en = 0 or i_corrupt_mode = 1.
- LFSR:
  - 16-bit Galois, polynomial 0xB400 (x^16+x^14+x^13+x^11+1), shift right; feedback is applied when the LSB = 1.
  - Advances every cycle that i_corrupt_en = 1, regardless of mode or link state.
  - Holds otherwise; never reset except by i_rst.
- Lane pointer: advances (i_ptr + 1) mod LANES after each flip. With LANES = 1 it stays 0.
- o_err_pulse: registered; high in cycle n+1 for a flip injected in cycle n.
- o_err_cnt:
  - Increments by 1 per flip and saturates at 16'hFFFF.
  - i_cnt_clr has priority: in a cycle with both clear and a flip, the count becomes 0 and that flip is not counted. o_err_pulse still fires.
- Mode change mid-run: takes effect the next cycle. Switching to LFSR mode zeros the period counter.

Decomposition:
- Package otn_link_pkg:
  - LFSR_POLY = 16'hB400.
  - DATA_IDLE = 1'b1, ACK_IDLE = 1'b0.
  - ERR_CNT_W = 16.
- Sub-module otn_delay_line: parametrised by WIDTH, DEPTH and RST_VAL; shift register with asynchronous active-low reset. It is instantiated twice: data (LANES, DATA_DELAY, all ones) and ack (LANES, ACK_DELAY, zero).

Test Plan:
- Reset values: hold i_rst low with random inputs -> o_otn_rx_data = all ones, o_otn_tx_ack = 0, o_err_cnt = 0, o_err_pulse = 0 throughout.
- Latency (LANES = 2, DATA_DELAY = 8, ACK_DELAY = 4): drive data 2'b01 for one cycle at cycle 10 -> 2'b01 on o_otn_rx_data at cycle 18 only. Ack pulse 2'b10 at cycle 20 -> output at cycle 24.
- Periodic injection (LANES = 2, ERR_INTERVAL = 16): data held 2'b11, corrupt_en high 64 cycles -> 4 flips, lanes 0,1,0,1, each 16 cycles apart. Pulses observed; o_err_cnt = 4.
- LFSR mode (ERR_MASK = 16'h0003, seed 16'hACE1): compare flip cycles against a reference LFSR model over 1000 cycles -> exact match of flip cycles and count.
- Link down: drop i_link_up for 20 cycles with corrupt_en high -> data idle all ones and ack 0 from +DATA_DELAY/+ACK_DELAY. No flips; counter frozen. Traffic resumes after the delay.
- Clear priority and saturation: (a) i_cnt_clr coincident with a flip -> count 0, pulse high; (b) ERR_INTERVAL = 1 for 70000 cycles -> o_err_cnt stays 16'hFFFF. (c) Async reset mid-stream -> outputs return to idle immediately.
